// File: rtl/icache_fill_unit_pkg.sv
// ----------------------------------------------------------------------------
// icache_fill_unit_pkg
//   Shared definitions for the instruction cache fill unit: machine word
//   width, default geometry, FSM state encoding and a saturating increment
//   used by the optional statistics counters.
//   No ports (package only).
// ----------------------------------------------------------------------------
package icache_fill_unit_pkg;

    // Machine word width (fetch address and instruction width).
    localparam int WORD_SIZE      = 16;

    // Default geometry: 4 lines of 4 words.
    localparam int DEF_LINES      = 4;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [0:0] {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_e;

    localparam logic [WORD_SIZE-1:0] STAT_MAX = '1;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] value);
        return (value == STAT_MAX) ? value : value + WORD_SIZE'(1);
    endfunction

endpackage

// File: rtl/icache_fill_unit_line_store.sv
// ----------------------------------------------------------------------------
// icache_fill_unit_line_store
//   Storage for the direct-mapped instruction cache: data words, one tag per
//   line and one valid bit per line.
//   Read port is asynchronous (same-cycle hit); all writes are synchronous.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset (clears valid bits)
//   rd_index_i      line selected by the fetch address
//   rd_offset_i     word within that line
//   rd_data_o       stored word at {rd_index_i, rd_offset_i}
//   rd_tag_o        tag stored for line rd_index_i
//   rd_valid_o      valid bit of line rd_index_i
//   wr_en_i         write wr_data_i into {wr_index_i, wr_offset_i}
//   wr_index_i      line being refilled (also the line set_en_i marks valid)
//   wr_offset_i     word being refilled
//   wr_data_i       refill data
//   set_en_i        store set_tag_i and mark line wr_index_i valid
//   set_tag_i       tag of the line being refilled
//   clr_en_i        invalidate line clr_index_i
//   clr_index_i     line to invalidate
//   clr_all_i       invalidate every line (wins over set/clear)
// ----------------------------------------------------------------------------
module icache_fill_unit_line_store
    import icache_fill_unit_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int IDX_W      = $clog2(LINES),
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = WORD_SIZE - IDX_W - OFF_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IDX_W-1:0]     rd_index_i,
    input  logic [OFF_W-1:0]     rd_offset_i,
    output logic [WORD_SIZE-1:0] rd_data_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic                 rd_valid_o,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_index_i,
    input  logic [OFF_W-1:0]     wr_offset_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    input  logic                 set_en_i,
    input  logic [TAG_W-1:0]     set_tag_i,
    input  logic                 clr_en_i,
    input  logic [IDX_W-1:0]     clr_index_i,
    input  logic                 clr_all_i
);

    logic [WORD_SIZE-1:0] data_mem [LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     valid_d;

    assign rd_data_o  = data_mem[{rd_index_i, rd_offset_i}];
    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];

    // Data and tags carry no reset: a line is only ever read after its valid
    // bit has been set by a complete refill.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_mem[{wr_index_i, wr_offset_i}] <= wr_data_i;
        end
        if (set_en_i) begin
            tag_mem[wr_index_i] <= set_tag_i;
        end
    end

    // Set (refill done) and per-line clear (miss start) never coincide: one
    // happens only while filling, the other only while idle.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            localparam logic [IDX_W-1:0] LINE_ID = IDX_W'(gi);
            assign valid_d[gi] = clr_all_i                               ? 1'b0 :
                                 (set_en_i && (wr_index_i == LINE_ID))  ? 1'b1 :
                                 (clr_en_i && (clr_index_i == LINE_ID)) ? 1'b0 :
                                                                          valid_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/icache_fill_unit.sv
// ----------------------------------------------------------------------------
// icache_fill_unit
//   Direct-mapped read-only instruction cache between the fetch port and a
//   multi-cycle instruction memory. Hits are served combinationally; a miss
//   stalls fetch (cpu_ready=0) while the whole line is refilled one word per
//   memory beat, after which the pending address hits.
//
// Optional feature (macro ICACHE_STATS_EN): adds saturating hit_count and
//   miss_count outputs. Without the macro those ports do not exist.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   cpu_read    fetch request
//   cpu_addr    fetch word address (held stable while cpu_ready=0)
//   cpu_data    instruction word (last served value while cpu_ready=0)
//   cpu_ready   1 = cpu_data valid this cycle, 0 = stall fetch
//   flush       invalidate all lines
//   mem_read    memory word-read request (level, registered)
//   mem_addr    memory word address (registered)
//   mem_data    memory read data
//   mem_valid   mem_data valid for the current mem_addr (one beat)
//   hit_count   served hits   (ICACHE_STATS_EN only)
//   miss_count  line refills  (ICACHE_STATS_EN only)
// ----------------------------------------------------------------------------
module icache_fill_unit
    import icache_fill_unit_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    output logic [WORD_SIZE-1:0] cpu_data,
    output logic                 cpu_ready,
    input  logic                 flush,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    icache_state_e        state_q;
    logic                 mem_read_q;
    logic [WORD_SIZE-1:0] mem_addr_q;
    logic [OFF_W-1:0]     beat_q;
    logic [OFF_W-1:0]     beat_d;
    logic                 flush_pend_q;
    logic [WORD_SIZE-1:0] cpu_data_q;
    logic [WORD_SIZE-1:0] line_base_d;

    logic [TAG_W-1:0]     cpu_tag;
    logic [IDX_W-1:0]     cpu_index;
    logic [OFF_W-1:0]     cpu_offset;
    logic [WORD_SIZE-1:0] line_rd_data;
    logic [TAG_W-1:0]     line_rd_tag;
    logic                 line_rd_valid;

    logic                 is_idle;
    logic                 tag_match;
    logic                 hit;
    logic                 miss;
    logic                 beat_accept;
    logic                 last_beat;
    logic                 line_set;

    assign cpu_tag    = cpu_addr[WORD_SIZE-1 -: TAG_W];
    assign cpu_index  = cpu_addr[OFF_W +: IDX_W];
    assign cpu_offset = cpu_addr[OFF_W-1:0];

    assign is_idle     = (state_q == ICACHE_IDLE);
    assign tag_match   = line_rd_valid && (line_rd_tag == cpu_tag);
    assign hit         = is_idle && cpu_read && tag_match;
    assign miss        = is_idle && cpu_read && !tag_match;
    assign beat_accept = (state_q == ICACHE_FILL) && mem_valid;
    assign last_beat   = (beat_q == LAST_BEAT);
    // A flush seen at any point of the fill (including the final beat)
    // leaves the refilled line invalid.
    assign line_set    = beat_accept && last_beat && !flush_pend_q && !flush;

    assign beat_d      = beat_q + OFF_W'(1);
    assign line_base_d = {cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};

    assign cpu_ready = hit;
    assign cpu_data  = hit ? line_rd_data : cpu_data_q;
    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;

    icache_fill_unit_line_store #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_line_store (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_index_i  (cpu_index),
        .rd_offset_i (cpu_offset),
        .rd_data_o   (line_rd_data),
        .rd_tag_o    (line_rd_tag),
        .rd_valid_o  (line_rd_valid),
        .wr_en_i     (beat_accept),
        .wr_index_i  (mem_addr_q[OFF_W +: IDX_W]),
        .wr_offset_i (beat_q),
        .wr_data_i   (mem_data),
        .set_en_i    (line_set),
        .set_tag_i   (mem_addr_q[WORD_SIZE-1 -: TAG_W]),
        .clr_en_i    (miss),
        .clr_index_i (cpu_index),
        .clr_all_i   (flush)
    );

    // Refill FSM. mem_addr keeps the tag/index of the line being filled and
    // only its offset field advances, so the address never carries into the
    // tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ICACHE_IDLE;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            cpu_data_q   <= '0;
        end else begin
            if (hit) begin
                cpu_data_q <= line_rd_data;
            end
            case (state_q)
                ICACHE_IDLE: begin
                    if (miss) begin
                        state_q      <= ICACHE_FILL;
                        mem_read_q   <= 1'b1;
                        mem_addr_q   <= line_base_d;
                        beat_q       <= '0;
                        flush_pend_q <= 1'b0;
                    end
                end
                ICACHE_FILL: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_valid) begin
                        if (last_beat) begin
                            state_q      <= ICACHE_IDLE;
                            mem_read_q   <= 1'b0;
                            beat_q       <= '0;
                            flush_pend_q <= 1'b0;
                        end else begin
                            beat_q                 <= beat_d;
                            mem_addr_q[OFF_W-1:0]  <= beat_d;
                        end
                    end
                end
                default: begin
                    state_q <= ICACHE_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [WORD_SIZE-1:0] hit_count_q;
    logic [WORD_SIZE-1:0] miss_count_q;

    // A miss is counted once, on the cycle that launches the refill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit) begin
                hit_count_q <= sat_inc(hit_count_q);
            end
            if (miss) begin
                miss_count_q <= sat_inc(miss_count_q);
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_fill_unit.sv
// ----------------------------------------------------------------------------
// tb_icache_fill_unit
//   Self-checking bench for icache_fill_unit. A memory responder with random
//   per-beat latency feeds refills; a line-level cache model (valid/tag/data
//   per line, computed from address arithmetic) predicts hit or miss, the
//   served word, the beat address sequence and the stall length.
//   Build with +define+ICACHE_STATS_EN to also check the statistics outputs.
// ----------------------------------------------------------------------------
module tb_icache_fill_unit;

    localparam int LINES = 4;
    localparam int LW    = 4;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        cpu_read  = 1'b0;
    logic [15:0] cpu_addr  = '0;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        flush     = 1'b0;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_data  = '0;
    logic        mem_valid = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    always #5 clk = ~clk;

    icache_fill_unit #(
        .LINES      (LINES),
        .LINE_WORDS (LW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_read   (cpu_read),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready),
        .flush      (flush),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Reference model state.
    logic        m_valid [LINES];
    int          m_tag   [LINES];
    logic [15:0] m_data  [LINES][LW];
    int          m_hits    = 0;
    int          m_misses  = 0;
    logic [15:0] mem_key   = 16'hA5A5;
    int          fixed_lat = 0;
    int          lat_sum   = 0;
    logic [15:0] obs [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check_eq("hit_count", 32'(hit_count), 32'(m_hits));
        check_eq("miss_count", 32'(miss_count), 32'(m_misses));
`endif
    endtask

    // Memory: each beat answers after 1..3 cycles (or fixed_lat); every
    // answered address is logged in obs. Outside a request, mem_valid toggles
    // randomly with junk data, which the cache must ignore.
    initial begin : mem_model
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 1;
        forever begin
            @(negedge clk);
            if (mem_read && reset_n) begin
                cnt++;
                if (cnt >= cur_lat) begin
                    mem_valid = 1'b1;
                    mem_data  = mem_addr ^ mem_key;
                    obs.push_back(mem_addr);
                    lat_sum += cur_lat;
                    cnt = 0;
                    cur_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
                end else begin
                    mem_valid = 1'b0;
                    mem_data  = 16'($urandom);
                end
            end else begin
                cnt = 0;
                cur_lat   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
                mem_valid = ($urandom_range(0, 3) == 0);
                mem_data  = 16'($urandom);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        flush    = 1'b0;
        #1;
        check_eq("rst_ready", 32'(cpu_ready), 32'd0);
        check_eq("rst_data", 32'(cpu_data), 32'd0);
        check_eq("rst_memrd", 32'(mem_read), 32'd0);
        check_eq("rst_memaddr", 32'(mem_addr), 32'd0);
        model_clear();
        m_hits = 0;
        m_misses = 0;
        check_stats();
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset applied");
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cpu_read = 1'b0;
        flush    = 1'b0;
        cpu_addr = 16'($urandom);
        #1;
        check_eq("idle_ready", 32'(cpu_ready), 32'd0);
        check_eq("idle_memrd", 32'(mem_read), 32'd0);
        $display("idle addr %04h", cpu_addr);
    endtask

    // One fetch transaction. Options: flush_at>0 pulses flush in the fill
    // cycle where that many beats have been answered; flush_idle pulses flush
    // with the request; drop lowers cpu_read right after the miss; reset_at>0
    // asserts reset_n once that many beats have been answered.
    task automatic fetch(input logic [15:0] addr, input int flush_at, input bit flush_idle,
                         input bit drop, input int reset_at);
        int  idx, off, tag, base, stalls, fills;
        bit  flushed, done, aborted, was_hit;
        idx  = (int'(addr) / LW) % LINES;
        off  = int'(addr) % LW;
        tag  = int'(addr) / (LW * LINES);
        base = int'(addr) - off;
        @(negedge clk);
        cpu_read = 1'b1;
        cpu_addr = addr;
        flush    = flush_idle;
        obs.delete();
        lat_sum  = 0;
        #1;
        was_hit = m_valid[idx] && (m_tag[idx] == tag);
        if (flush_idle) model_clear();
        if (was_hit) begin
            check_eq("hit_ready", 32'(cpu_ready), 32'd1);
            check_eq("hit_data", 32'(cpu_data), 32'(m_data[idx][off]));
            check_eq("hit_memrd", 32'(mem_read), 32'd0);
            m_hits++;
            $display("fetch %04h hit data %04h flush=%0d", addr, cpu_data, flush_idle);
        end else begin
            check_eq("miss_ready", 32'(cpu_ready), 32'd0);
            stalls  = 1;
            fills   = 1;
            flushed = 1'b0;
            done    = 1'b0;
            aborted = 1'b0;
            for (int cyc = 0; cyc < 400 && !done; cyc++) begin
                @(negedge clk);
                flush = 1'b0;
                if (drop) cpu_read = 1'b0;
                #1;
                if (reset_at > 0 && obs.size() == reset_at) begin
                    reset_n = 1'b0;
                    #1;
                    check_eq("midrst_memrd", 32'(mem_read), 32'd0);
                    check_eq("midrst_ready", 32'(cpu_ready), 32'd0);
                    check_eq("midrst_data", 32'(cpu_data), 32'd0);
                    check_eq("midrst_memaddr", 32'(mem_addr), 32'd0);
                    model_clear();
                    m_hits = 0;
                    m_misses = 0;
                    check_stats();
                    cpu_read = 1'b0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    done    = 1'b1;
                    aborted = 1'b1;
                end else if (drop) begin
                    check_eq("drop_ready", 32'(cpu_ready), 32'd0);
                    if (obs.size() == LW && !mem_read) done = 1'b1;
                end else if (cpu_ready) begin
                    check_eq("fill_data", 32'(cpu_data), 32'(16'(int'(addr)) ^ mem_key));
                    check_eq("fill_memrd", 32'(mem_read), 32'd0);
                    done = 1'b1;
                end else begin
                    stalls++;
                    if (!flushed && flush_at > 0 && obs.size() == flush_at) begin
                        flush   = 1'b1;
                        flushed = 1'b1;
                        fills   = 2;
                        model_clear();
                    end
                end
            end
            if (!done) begin
                check_eq("fill_timeout", 32'd0, 32'd1);
            end else if (aborted) begin
                $display("fetch %04h aborted by reset after %0d beats", addr, reset_at);
            end else begin
                check_eq("beat_count", 32'(obs.size()), 32'(fills * LW));
                for (int i = 0; i < obs.size(); i++) begin
                    check_eq("beat_addr", 32'(obs[i]), 32'(base + (i % LW)));
                end
                if (!drop) begin
                    check_eq("stall_cycles", 32'(stalls), 32'(lat_sum + fills));
                    m_hits++;
                end
                m_misses += fills;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                for (int w = 0; w < LW; w++) m_data[idx][w] = 16'(base + w) ^ mem_key;
                $display("fetch %04h miss fills=%0d stalls=%0d drop=%0d flush_at=%0d",
                         addr, fills, stalls, drop, flush_at);
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int r;
        int fa;
        bit fi, dr;
        int ra;
        apply_reset();

        // Cold miss with fixed latency 2.
        fixed_lat = 2;
        mem_key   = 16'hA5A5;
        fetch(16'h0005, 0, 1'b0, 1'b0, 0);
        check_eq("t1_data", 32'(cpu_data), 32'h0000A5A0);
        fixed_lat = 0;

        // Hits across the freshly filled line.
        for (int a = 4; a < 8; a++) fetch(16'(a), 0, 1'b0, 1'b0, 0);

        // Conflict on the same index, then the original line again.
        fetch(16'h0014, 0, 1'b0, 1'b0, 0);
        fetch(16'h0004, 0, 1'b0, 1'b0, 0);
        idle_cycle();
`ifdef ICACHE_STATS_EN
        check_eq("t3_miss_count", 32'(miss_count), 32'd3);
`endif
        check_stats();

        // Flush during a fill, then flush while idle.
        fetch(16'h0024, 1, 1'b0, 1'b0, 0);
        fetch(16'h0024, 0, 1'b0, 1'b0, 0);
        fetch(16'h0024, 0, 1'b1, 1'b0, 0);
        fetch(16'h0024, 0, 1'b0, 1'b0, 0);
        fetch(16'h0014, 0, 1'b0, 1'b0, 0);

        // Flush in the same cycle as the last beat.
        fetch(16'h0030, LW, 1'b0, 1'b0, 0);

        // Request dropped mid-fill; the line must still become valid.
        fetch(16'h0038, 0, 1'b0, 1'b1, 0);
        fetch(16'h003A, 0, 1'b0, 1'b0, 0);

        // Reset during beat 2, then a cold miss.
        fixed_lat = 2;
        fetch(16'h0008, 0, 1'b0, 1'b0, 3);
        fixed_lat = 0;
        fetch(16'h0005, 0, 1'b0, 1'b0, 0);

        // Randomised mix.
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                idle_cycle();
            end else if (r < 13) begin
                mem_key = 16'($urandom);
                $display("memory contents changed key %04h", mem_key);
            end else if (r < 15) begin
                apply_reset();
            end else begin
                fa = 0; fi = 1'b0; dr = 1'b0; ra = 0;
                r = int'($urandom_range(0, 99));
                if (r < 8)       fa = int'($urandom_range(1, LW));
                else if (r < 16) fi = 1'b1;
                else if (r < 24) dr = 1'b1;
                else if (r < 27) ra = int'($urandom_range(1, LW - 1));
                fetch(16'($urandom_range(0, 63)), fa, fi, dr, ra);
            end
        end

        idle_cycle();
        check_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
